// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the accumulator-core control
// sequencer. Holds the opcode, FSM state and branch-condition enums, the
// write-back source selectors and the reserved LDC argument meaning HALT.
package ctrl_pkg;

  typedef enum logic [2:0] {
    OP_SETSRC  = 3'd0,
    OP_SETDEST = 3'd1,
    OP_MOV     = 3'd2,
    OP_ALU     = 3'd3,
    OP_LOAD    = 3'd4,
    OP_STORE   = 3'd5,
    OP_BR      = 3'd6,
    OP_LDC     = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_FETCH  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'd0,
    BR_EQ     = 2'd1,
    BR_LT     = 2'd2,
    BR_NE     = 2'd3
  } br_cond_t;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_CONST = 2'd2;

  localparam logic [5:0] HALT_ARG = 6'h3F;

  // HALT is encoded as LDC with the all-ones argument.
  function automatic logic is_halt(input logic [8:0] ir);
    return (ir[8:6] == OP_LDC) && (ir[5:0] == HALT_ARG);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_branch_eval.sv
// branch_eval: combinational branch-condition evaluation.
// Ports:
//   cond  - 2-bit condition field of a BR instruction (always/eq/lt/ne)
//   eq    - registered equality flag from the last ALU instruction
//   lt    - registered less-than flag from the last ALU instruction
//   taken - 1 when the branch is taken
module branch_eval
  import ctrl_pkg::*;
(
  input  logic [1:0] cond,
  input  logic       eq,
  input  logic       lt,
  output logic       taken
);

  // Map the condition code onto the stored flags.
  always_comb begin
    taken = 1'b0;
    case (br_cond_t'(cond))
      BR_ALWAYS: taken = 1'b1;
      BR_EQ:     taken = eq;
      BR_LT:     taken = lt;
      BR_NE:     taken = ~eq;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control FSM for the 8-bit accumulator core.
// Owns the run state, latches each instruction, emits one-cycle strobes to
// fetch/reg_file/ALU/data_ram/LUTs, keeps the branch flags and counts
// retired instructions (saturating).
// Ports:
//   CLK, reset            - clock and synchronous active-high reset
//   go                    - run request (honoured only when idle or halted)
//   instruction           - instr_rom word for the current PC
//   equal_flag, less_than_flag - live ALU compare results
//   start, pc_en, branch, branch_cond, offset_idx - fetch unit controls
//   setsrc, setdest, mov, regwrite, rt_index, wb_sel - reg_file controls
//   alu_op                - ALU operation
//   mem_read, mem_write, lut_mem_idx - data_ram controls and address LUT index
//   lut_const_idx         - constant LUT index
//   halt, done            - run status
//   instr_count           - retired-instruction count
//
// All outputs are registered: each edge computes the outputs for the state
// being entered, so a strobe is high for exactly the cycle of its state.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int IW    = 9,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             go,
  input  logic [IW-1:0]    instruction,
  input  logic             equal_flag,
  input  logic             less_than_flag,
  output logic             start,
  output logic             pc_en,
  output logic             branch,
  output logic             branch_cond,
  output logic [2:0]       offset_idx,
  output logic             setsrc,
  output logic             setdest,
  output logic             mov,
  output logic             regwrite,
  output logic [2:0]       rt_index,
  output logic [1:0]       wb_sel,
  output logic [2:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic [5:0]       lut_mem_idx,
  output logic [2:0]       lut_const_idx,
  output logic             halt,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t          state_r;
  logic [IW-1:0]   ir_r;
  logic            eq_r;
  logic            lt_r;

  opcode_t         fetch_op_s;
  logic [5:0]      fetch_arg_s;
  opcode_t         exec_op_s;
  logic            taken_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign fetch_op_s  = opcode_t'(instruction[8:6]);
  assign fetch_arg_s = instruction[5:0];
  assign exec_op_s   = opcode_t'(ir_r[8:6]);
  assign cnt_inc_s   = (instr_count == CNT_MAX) ? instr_count : instr_count + CNT_ONE;

  // The branch decision is needed at the FETCH edge, where the EXEC-cycle
  // strobes are registered, so it evaluates the incoming instruction.
  branch_eval u_branch_eval (
    .cond  (instruction[5:4]),
    .eq    (eq_r),
    .lt    (lt_r),
    .taken (taken_s)
  );

  // Sequencer FSM: state, instruction register, flags, counter and strobes.
  always_ff @(posedge CLK) begin
    // Strobes default low every cycle so each one lasts exactly one cycle.
    start         <= 1'b0;
    pc_en         <= 1'b0;
    branch        <= 1'b0;
    branch_cond   <= 1'b0;
    offset_idx    <= 3'd0;
    setsrc        <= 1'b0;
    setdest       <= 1'b0;
    mov           <= 1'b0;
    regwrite      <= 1'b0;
    rt_index      <= 3'd0;
    wb_sel        <= WB_ALU;
    alu_op        <= 3'd0;
    mem_read      <= 1'b0;
    mem_write     <= 1'b0;
    lut_mem_idx   <= 6'd0;
    lut_const_idx <= 3'd0;
    halt          <= 1'b0;
    done          <= 1'b0;

    if (reset) begin
      state_r     <= ST_IDLE;
      ir_r        <= '0;
      eq_r        <= 1'b0;
      lt_r        <= 1'b0;
      instr_count <= '0;
      halt        <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go) begin
            state_r <= ST_LAUNCH;
            start   <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            halt    <= 1'b1;
          end
        end

        ST_LAUNCH: begin
          state_r <= ST_FETCH;
        end

        ST_FETCH: begin
          ir_r    <= instruction;
          state_r <= ST_EXEC;
          case (fetch_op_s)
            OP_SETSRC: begin
              setsrc   <= 1'b1;
              rt_index <= fetch_arg_s[2:0];
              pc_en    <= 1'b1;
            end
            OP_SETDEST: begin
              setdest  <= 1'b1;
              rt_index <= fetch_arg_s[2:0];
              pc_en    <= 1'b1;
            end
            OP_MOV: begin
              mov      <= 1'b1;
              rt_index <= fetch_arg_s[2:0];
              pc_en    <= 1'b1;
            end
            OP_ALU: begin
              regwrite <= 1'b1;
              wb_sel   <= WB_ALU;
              alu_op   <= fetch_arg_s[2:0];
              pc_en    <= 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              lut_mem_idx <= fetch_arg_s;
            end
            OP_BR: begin
              branch      <= 1'b1;
              branch_cond <= taken_s;
              pc_en       <= ~taken_s;
              offset_idx  <= fetch_arg_s[2:0];
            end
            OP_LDC: begin
              // HALT leaves every strobe low, including pc_en.
              if (!is_halt(instruction)) begin
                regwrite      <= 1'b1;
                wb_sel        <= WB_CONST;
                pc_en         <= 1'b1;
                lut_const_idx <= fetch_arg_s[2:0];
              end else begin
                regwrite <= 1'b0;
              end
            end
            default: begin
              pc_en <= 1'b0;
            end
          endcase
        end

        ST_EXEC: begin
          case (exec_op_s)
            OP_ALU: begin
              eq_r        <= equal_flag;
              lt_r        <= less_than_flag;
              instr_count <= cnt_inc_s;
              state_r     <= ST_FETCH;
            end
            OP_LOAD: begin
              mem_read    <= 1'b1;
              lut_mem_idx <= ir_r[5:0];
              state_r     <= ST_MEM;
            end
            OP_STORE: begin
              mem_write   <= 1'b1;
              pc_en       <= 1'b1;
              lut_mem_idx <= ir_r[5:0];
              state_r     <= ST_MEM;
            end
            OP_LDC: begin
              instr_count <= cnt_inc_s;
              if (is_halt(ir_r)) begin
                state_r <= ST_HALTED;
                halt    <= 1'b1;
                done    <= 1'b1;
              end else begin
                state_r <= ST_FETCH;
              end
            end
            default: begin
              instr_count <= cnt_inc_s;
              state_r     <= ST_FETCH;
            end
          endcase
        end

        ST_MEM: begin
          if (exec_op_s == OP_LOAD) begin
            mem_read    <= 1'b1;
            regwrite    <= 1'b1;
            wb_sel      <= WB_MEM;
            pc_en       <= 1'b1;
            lut_mem_idx <= ir_r[5:0];
            state_r     <= ST_WB;
          end else begin
            instr_count <= cnt_inc_s;
            state_r     <= ST_FETCH;
          end
        end

        ST_WB: begin
          instr_count <= cnt_inc_s;
          state_r     <= ST_FETCH;
        end

        ST_HALTED: begin
          if (go) begin
            instr_count <= '0;
            eq_r        <= 1'b0;
            lt_r        <= 1'b0;
            start       <= 1'b1;
            state_r     <= ST_LAUNCH;
          end else begin
            halt    <= 1'b1;
            done    <= 1'b1;
            state_r <= ST_HALTED;
          end
        end

        default: begin
          halt    <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed scenarios followed by a
// random instruction stream, compared cycle by cycle against a per-instruction
// behavioural model (instruction latency table plus expected strobes).
module tb_ctrl_sequencer;
  localparam int CW = 4;  // narrow counter so saturation is reachable

  typedef struct packed {
    logic       start, pc_en, branch, branch_cond;
    logic [2:0] offset_idx;
    logic       setsrc, setdest, mov, regwrite;
    logic [2:0] rt_index;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic       mem_read, mem_write;
    logic [5:0] lut_mem_idx;
    logic [2:0] lut_const_idx;
    logic       halt, done;
  } outs_t;

  logic CLK = 1'b0;
  logic reset, go, equal_flag, less_than_flag;
  logic [8:0] instruction;
  logic start, pc_en, branch, branch_cond, setsrc, setdest, mov, regwrite;
  logic mem_read, mem_write, halt, done;
  logic [2:0] offset_idx, rt_index, alu_op, lut_const_idx;
  logic [1:0] wb_sel;
  logic [5:0] lut_mem_idx;
  logic [CW-1:0] instr_count;
  outs_t obs;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CW-1:0] cnt_m;
  logic eq_m, lt_m, halted_m;

  always #5 CLK = ~CLK;

  ctrl_sequencer #(.IW(9), .CNT_W(CW)) dut (
    .CLK(CLK), .reset(reset), .go(go), .instruction(instruction),
    .equal_flag(equal_flag), .less_than_flag(less_than_flag),
    .start(start), .pc_en(pc_en), .branch(branch), .branch_cond(branch_cond),
    .offset_idx(offset_idx), .setsrc(setsrc), .setdest(setdest), .mov(mov),
    .regwrite(regwrite), .rt_index(rt_index), .wb_sel(wb_sel), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .lut_mem_idx(lut_mem_idx),
    .lut_const_idx(lut_const_idx), .halt(halt), .done(done),
    .instr_count(instr_count)
  );

  assign obs = {start, pc_en, branch, branch_cond, offset_idx, setsrc, setdest,
                mov, regwrite, rt_index, wb_sel, alu_op, mem_read, mem_write,
                lut_mem_idx, lut_const_idx, halt, done};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Cycles per instruction: LOAD 4, STORE 3, everything else 2.
  function automatic int instr_len(input logic [8:0] ins);
    if (ins[8:6] == 3'd4) return 4;
    if (ins[8:6] == 3'd5) return 3;
    return 2;
  endfunction

  // Expected outputs in cycle ph of an instruction (0 = fetch cycle).
  function automatic outs_t model_outs(input logic [8:0] ins, input int ph,
                                       input logic eqv, input logic ltv);
    outs_t o;
    logic [5:0] arg;
    logic tk;
    o   = '0;
    arg = ins[5:0];
    if (ph == 0) return o;
    case (int'(ins[8:6]))
      0: begin o.setsrc = 1'b1;  o.rt_index = arg[2:0]; o.pc_en = 1'b1; end
      1: begin o.setdest = 1'b1; o.rt_index = arg[2:0]; o.pc_en = 1'b1; end
      2: begin o.mov = 1'b1;     o.rt_index = arg[2:0]; o.pc_en = 1'b1; end
      3: begin o.regwrite = 1'b1; o.wb_sel = 2'd0; o.alu_op = arg[2:0]; o.pc_en = 1'b1; end
      4: begin
        o.lut_mem_idx = arg;
        if (ph >= 2) o.mem_read = 1'b1;
        if (ph == 3) begin o.regwrite = 1'b1; o.wb_sel = 2'd1; o.pc_en = 1'b1; end
      end
      5: begin
        o.lut_mem_idx = arg;
        if (ph == 2) begin o.mem_write = 1'b1; o.pc_en = 1'b1; end
      end
      6: begin
        case (arg[5:4])
          2'b00:   tk = 1'b1;
          2'b01:   tk = eqv;
          2'b10:   tk = ltv;
          default: tk = ~eqv;
        endcase
        o.branch = 1'b1; o.branch_cond = tk; o.pc_en = ~tk; o.offset_idx = arg[2:0];
      end
      default: begin
        if (arg != 6'h3F) begin
          o.regwrite = 1'b1; o.wb_sel = 2'd2; o.pc_en = 1'b1; o.lut_const_idx = arg[2:0];
        end
      end
    endcase
    return o;
  endfunction

  // Idle/halted cycles with go low.
  task automatic wait_stopped(input int n);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.halt = 1'b1; e.done = halted_m;
      check_eq("stopped_outs", obs, e);
      check_eq("stopped_count", 32'(instr_count), 32'(cnt_m));
      go = 1'b0; instruction = 9'($urandom);
      tick();
    end
  endtask

  // One-cycle go from IDLE/HALTED, then the LAUNCH cycle.
  task automatic launch();
    outs_t e;
    e = '0; e.halt = 1'b1; e.done = halted_m;
    check_eq("pre_go_outs", obs, e);
    go = 1'b1;
    tick();
    if (halted_m) begin cnt_m = '0; eq_m = 1'b0; lt_m = 1'b0; end
    halted_m = 1'b0;
    e = '0; e.start = 1'b1;
    check_eq("launch_outs", obs, e);
    check_eq("launch_count", 32'(instr_count), 32'(cnt_m));
    go = 1'b1;  // must be ignored while running
    tick();
  endtask

  // Execute one instruction. fl < 0 randomises the ALU flags, otherwise
  // bit0 = equal_flag and bit1 = less_than_flag. rst_ph >= 0 asserts reset
  // during that cycle of the instruction.
  task automatic run_instr(input logic [8:0] ins, input int fl, input int rst_ph,
                           output bit aborted);
    outs_t e;
    int len, pcs;
    logic eq_n, lt_n;
    len = instr_len(ins); pcs = 0; aborted = 1'b0; eq_n = eq_m; lt_n = lt_m;
    for (int ph = 0; ph < len; ph++) begin
      e = model_outs(ins, ph, eq_m, lt_m);
      check_eq($sformatf("outs_op%0d_ph%0d", ins[8:6], ph), obs, e);
      check_eq("count", 32'(instr_count), 32'(cnt_m));
      pcs += int'(obs.pc_en) + int'(obs.branch & obs.branch_cond);
      instruction    = (ph == 0) ? ins : 9'($urandom);
      equal_flag     = (fl < 0) ? 1'($urandom) : fl[0];
      less_than_flag = (fl < 0) ? 1'($urandom) : fl[1];
      go             = 1'($urandom);
      reset          = (ph == rst_ph);
      if (ph == 1 && ins[8:6] == 3'd3) begin eq_n = equal_flag; lt_n = less_than_flag; end
      tick();
      if (reset) begin
        reset = 1'b0; go = 1'b0;
        cnt_m = '0; eq_m = 1'b0; lt_m = 1'b0; halted_m = 1'b0;
        aborted = 1'b1;
        return;
      end
      eq_m = eq_n; lt_m = lt_n;
    end
    if (cnt_m != '1) cnt_m = cnt_m + 1'b1;
    if (ins == 9'o777) halted_m = 1'b1;
    else check_eq("pc_once", 32'(pcs), 32'd1);
  endtask

  initial begin
    bit ab;
    logic [8:0] ins;
    int rp;
    reset = 1'b1; go = 1'b0; instruction = '0; equal_flag = 1'b0; less_than_flag = 1'b0;
    cnt_m = '0; eq_m = 1'b0; lt_m = 1'b0; halted_m = 1'b0;
    tick(); tick();
    reset = 1'b0;
    wait_stopped(2);
    launch();

    // Directed: register setup, ALU, memory, branches, halt/restart.
    run_instr(9'o002, -1, -1, ab);
    run_instr(9'o300, -1, -1, ab);
    check_eq("count_after_two", 32'(instr_count), 32'd2);
    run_instr(9'o405, -1, -1, ab);
    run_instr(9'o505, -1, -1, ab);
    run_instr(9'o300, 1, -1, ab);
    run_instr(9'o623, -1, -1, ab);
    run_instr(9'o300, 0, -1, ab);
    run_instr(9'o623, -1, -1, ab);
    run_instr(9'o700, -1, -1, ab);
    run_instr(9'o623, -1, -1, ab);  // LDC must not disturb flags
    run_instr(9'o777, -1, -1, ab);
    wait_stopped(3);
    launch();
    // Reset during the MEM cycle of a STORE.
    run_instr(9'o301, 2, -1, ab);
    run_instr(9'o505, -1, 2, ab);
    wait_stopped(2);
    launch();
    // Counter saturation.
    for (int i = 0; i < 20; i++) run_instr(9'o011, -1, -1, ab);
    check_eq("count_saturated", 32'(instr_count), 32'(4'hF));

    // Random stream.
    for (int i = 0; i < 400; i++) begin
      ins = 9'($urandom);
      if ($urandom_range(15) == 0) ins = 9'o777;
      rp = ($urandom_range(31) == 0) ? int'($urandom_range(instr_len(ins) - 1)) : -1;
      run_instr(ins, -1, rp, ab);
      if (ab || halted_m) begin
        wait_stopped(int'($urandom_range(1, 3)));
        launch();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
